// File: rtl/spike_dec_pkg.sv
// Shared types and constants for the spike rate decoder.
// Holds the FSM state encoding and the default rate width.
package spike_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

    localparam int unsigned RATE_W_DEF = 8;

    localparam logic [RATE_W_DEF-1:0] SAT_MAX = '1;

    // All-ones value of a given width, used as the saturation ceiling.
    function automatic logic [31:0] sat_max_of(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/spike_window_counter.sv
// Window and spike counters for the spike rate decoder.
// Emits the saturated window count and a window-end strobe.
module spike_window_counter
    import spike_dec_pkg::*;
#(
    parameter int WIN_LOG2 = 7,
    parameter int RATE_W   = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              count_en_i,
    input  logic              clear_i,
    input  logic              spike_i,
    output logic [RATE_W-1:0] final_o,
    output logic              win_end_o
);

    localparam logic [WIN_LOG2-1:0] WCNT_MAX = '1;
    localparam logic [RATE_W-1:0]   SCNT_MAX =
        RATE_W'(sat_max_of(RATE_W));

    logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
    logic [RATE_W-1:0]   scnt_q, scnt_d;
    logic [RATE_W-1:0]   sum;
    logic                win_end;

    // Saturating spike sum including the current cycle's sample.
    always_comb begin
        sum = scnt_q;
        if (spike_i && (scnt_q != SCNT_MAX)) begin
            sum = scnt_q + RATE_W'(1);
        end
    end

    assign win_end   = count_en_i && (wcnt_q == WCNT_MAX);
    assign win_end_o = win_end;
    assign final_o   = sum;

    // Next-state for the counters: clear, advance, or hold.
    always_comb begin
        wcnt_d = wcnt_q;
        scnt_d = scnt_q;
        if (clear_i) begin
            wcnt_d = '0;
            scnt_d = '0;
        end else if (count_en_i) begin
            wcnt_d = wcnt_q + WIN_LOG2'(1);
            scnt_d = win_end ? '0 : sum;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            scnt_q <= scnt_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per window, presents rate with handshake.
// Optional smoothing of the rate via macro SPIKE_DEC_EMA_EN.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int WIN_LOG2 = 7,
    parameter int RATE_W   = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              spike_in,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    input  logic              rate_ready,
    output logic              overrun,
    input  logic              clr_overrun
);

    dec_state_e state_q, state_d;
    logic       count_en;
    logic       clear;

    logic [RATE_W-1:0] cnt;
    logic              win_end;
    logic [RATE_W-1:0] load_val;

    logic [RATE_W-1:0] rate_q, rate_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              can_load;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counting follows enable; a falling enable discards the window.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = RUN;
                    count_en = 1'b1;
                end else begin
                    clear = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clear   = 1'b1;
            end
        endcase
    end

    spike_window_counter #(
        .WIN_LOG2 (WIN_LOG2),
        .RATE_W   (RATE_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_en_i (count_en),
        .clear_i    (clear),
        .spike_i    (spike_in),
        .final_o    (cnt),
        .win_end_o  (win_end)
    );

`ifdef SPIKE_DEC_EMA_EN
    logic [RATE_W-1:0] ema_q, ema_d;

    // Smoothed rate; advances on every window end, even if dropped.
    always_comb begin
        ema_d = ema_q;
        if (win_end) begin
            ema_d = ema_q - (ema_q >> 2) + (cnt >> 2);
        end
    end

    // EMA accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ema_q <= '0;
        end else begin
            ema_q <= ema_d;
        end
    end

    assign load_val = ema_d;
`else
    assign load_val = cnt;
`endif

    assign can_load = !valid_q || rate_ready;

    // Output slot and sticky overrun; set beats clear.
    always_comb begin
        rate_d  = rate_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && rate_ready) begin
            valid_d = 1'b0;
        end
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (win_end) begin
            if (can_load) begin
                rate_d  = load_val;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Output slot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rate_q  <= rate_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 7, meaning the window length is 2^WIN_LOG2 cycles (legal range 1..12).
REQ-002 SHALL have parameter RATE_W, default 8, meaning the output rate width in bits.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: counting runs while high.
REQ-006 SHALL have port spike_in, input, 1 bit: one spike per high cycle, for example from an upstream LIF neuron.
REQ-007 SHALL have port rate, output, RATE_W bits: decoded spike count for the last completed window.
REQ-008 SHALL have port rate_valid, output, 1 bit: the rate output holds an unconsumed value.
REQ-009 SHALL have port rate_ready, input, 1 bit: the consumer accepts the value.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, set when a completed window is dropped.
REQ-011 SHALL have port clr_overrun, input, 1 bit: clears overrun.

Function
REQ-012 SHALL implement an FSM with two states: IDLE (enable low) and RUN (enable high). IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-013 SHALL, in RUN, sample spike_in every cycle and increment a window counter wcnt from 0 to 2^WIN_LOG2-1, wrapping to 0.
REQ-014 SHALL keep the spike counter scnt saturating at 2^RATE_W-1; it never wraps.
REQ-015 SHALL, in the window-end cycle (wcnt at max), form the final count as scnt+spike_in (saturated), then clear scnt to 0 at the next edge.
REQ-016 SHALL load the final count into rate on the window-end edge, with rate_valid=1 from the following cycle; latency is 1 cycle after the last sampled spike.
REQ-017 SHALL complete the handshake when rate_valid and rate_ready are both high; rate_valid drops at that edge unless a new value loads in the same edge.
REQ-018 SHALL, on a window end while rate_valid=1 and rate_ready=0, drop the new value, keep the old rate unchanged, and set overrun=1.
REQ-019 SHALL, on a window end coinciding with acceptance (valid and ready both high), load the new value and keep rate_valid=1 with no overrun.
REQ-020 SHALL hold rate and rate_valid stable while rate_ready=0.
REQ-021 SHALL, when enable falls mid-window, discard the partial count and reset wcnt and scnt to 0; the output slot is unaffected and the next RUN starts a full window.
REQ-022 SHALL give set priority when clr_overrun coincides with a new overrun event (overrun stays 1).

Reset
REQ-023 SHALL, while rst_n=0 at an edge, set FSM=IDLE, wcnt=0, scnt=0, rate=0, rate_valid=0, overrun=0, and EMA accumulator=0, regardless of any operation in progress.

Configuration
REQ-024 SHALL support the macro SPIKE_DEC_EMA_EN.
- Defined: on each window end, ema <= ema - (ema>>2) + (count>>2), and rate is loaded from the new ema value. The EMA update occurs even when the output value is dropped.
- Undefined: rate equals the raw saturated count and no EMA register exists.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, RUN), RATE_W default, and the saturation-max constant in shared package spike_dec_pkg.
REQ-026 SHALL factor the wcnt/scnt logic into sub-module spike_window_counter, which emits the final count and a window-end strobe; the top level owns the FSM, the output slot, overrun, and the EMA.

Verification
REQ-027 SHALL cover: WIN_LOG2=4, enable=1, spike_in=1 for 16 cycles, rate_ready=1 -> rate=16, rate_valid high for exactly 1 cycle, 1 cycle after the 16th sample.
REQ-028 SHALL cover: WIN_LOG2=9, spike_in=1 constant -> rate=255 (saturated), overrun=0.
REQ-029 SHALL cover: WIN_LOG2=4, spike every 2nd cycle, rate_ready=0 over two windows -> rate=8 held, overrun=1; after clr_overrun, overrun=0.
REQ-030 SHALL cover: WIN_LOG2=4, enable dropped after 8 spiking cycles then reasserted -> no output from the partial window; the next full window yields 16.
REQ-031 SHALL cover: rst_n=0 asserted for 1 cycle mid-window while rate_valid=1 -> all outputs 0 at the next cycle.
REQ-032 SHALL cover: SPIKE_DEC_EMA_EN defined, WIN_LOG2=4, constant count 16 -> successive rates 4, 7, 10, 12.
